spi_rx_fifo: RTL and testbench

Upstream of send_bytes. Samples the MCU's SPI link (sck, sdi, load) into the clk domain, assembles MSB-first bytes, and buffers them in a show-ahead FIFO. send_bytes drains bytes through a valid/ready handshake, so the MCU can burst a whole LED frame faster than the LED data stream is emitted.

---
 rtl/spi_rx_fifo_pkg.sv | 9 +
 rtl/spi_rx_fifo_sync_fifo.sv | 67 ++++++
 rtl/spi_rx_fifo.sv | 136 +++++++++++++
 tb/tb_spi_rx_fifo.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_rx_fifo_pkg.sv
// rtl/spi_rx_fifo_pkg.sv - shared types and constants for the SPI receive path
package spi_rx_pkg;

  typedef logic [7:0] byte_t;

  localparam int BITS_PER_BYTE   = 8;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/spi_rx_fifo_sync_fifo.sv
// rtl/spi_rx_fifo_sync_fifo.sv - show-ahead byte FIFO with occupancy count
module sync_fifo
  import spi_rx_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  byte_t                    wr_data,
  input  logic                     rd_en,
  output byte_t                    rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   LVL_ONE  = 1;
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

  byte_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    level_q;
  byte_t          last_q;
  logic           do_push;
  logic           do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LVL_FULL);
  assign level   = level_q;
  // A pop on an empty FIFO is meaningless; a push into a full FIFO only fits
  // when the head leaves in the same cycle.
  assign do_pop  = rd_en & ~empty;
  assign do_push = wr_en & (~full | do_pop);
  // While empty, the output keeps showing the last byte that was popped.
  assign rd_data = empty ? last_q : mem[rd_ptr];

  // Storage write; entries are only ever read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and the held output byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      last_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        last_q <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/spi_rx_fifo.sv
// rtl/spi_rx_fifo.sv - SPI slave byte receiver feeding a show-ahead FIFO (option: SPI_RX_PARTIAL_FLAG_EN)
module spi_rx_fifo
  import spi_rx_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sck,
  input  logic                     sdi,
  input  logic                     load,
  output byte_t                    rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     frame_done,
  output logic                     overflow
`ifdef SPI_RX_PARTIAL_FLAG_EN
  ,
  output logic                     partial_err
`endif
);

  localparam int SETTLE_W = SYNC_STAGES + 2;

  logic [SYNC_STAGES-1:0]   sck_sync;
  logic [SYNC_STAGES-1:0]   sdi_sync;
  logic [SYNC_STAGES-1:0]   load_sync;
  logic [1:0]               sck_h;
  logic [1:0]               load_h;
  logic                     sdi_q;
  logic [SETTLE_W-1:0]      settle;
  logic                     settled;

  logic                     armed;
  logic [BITS_PER_BYTE-2:0] shift_reg;
  logic [2:0]               bit_cnt;

  logic                     sck_rise;
  logic                     load_rise;
  logic                     load_fall;
  logic                     capture;
  logic                     push;
  logic                     pop;
  byte_t                    push_data;
  logic                     fifo_empty;
  logic                     fifo_full;

  // Synchronizer chains plus a two-sample history used for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync  <= '0;
      sdi_sync  <= '0;
      load_sync <= '0;
      sck_h     <= '0;
      load_h    <= '0;
      sdi_q     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      load_sync <= {load_sync[SYNC_STAGES-2:0], load};
      sck_h     <= {sck_h[0], sck_sync[SYNC_STAGES-1]};
      load_h    <= {load_h[0], load_sync[SYNC_STAGES-1]};
      sdi_q     <= sdi_sync[SYNC_STAGES-1];
    end
  end

  // Edges are ignored until the cleared chains have refilled with real input,
  // so a load held high through reset does not look like a fresh frame start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) settle <= '0;
    else       settle <= {settle[SETTLE_W-2:0], 1'b1};
  end

  assign settled   = settle[SETTLE_W-1];
  assign sck_rise  = settled & sck_h[0] & ~sck_h[1];
  assign load_rise = settled & load_h[0] & ~load_h[1];
  assign load_fall = settled & ~load_h[0] & load_h[1];
  assign capture   = sck_rise & load_h[0] & armed;
  assign push      = capture & (bit_cnt == 3'(BITS_PER_BYTE - 1));
  assign push_data = {shift_reg, sdi_q};
  assign pop       = rd_valid & rd_ready;
  assign rd_valid  = ~fifo_empty;

  // Frame tracking, bit assembly and the end-of-frame pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed      <= 1'b0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= load_fall;
      if (load_rise)      armed <= 1'b1;
      else if (load_fall) armed <= 1'b0;
      if (load_rise || load_fall) begin
        bit_cnt <= '0;
      end else if (capture) begin
        shift_reg <= push_data[BITS_PER_BYTE-2:0];
        bit_cnt   <= bit_cnt + 3'd1;
      end
    end
  end

  // Per-frame sticky drop flag; a same-cycle pop makes room so nothing is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         overflow <= 1'b0;
    else if (load_rise)                overflow <= 1'b0;
    else if (push && fifo_full && !pop) overflow <= 1'b1;
  end

`ifdef SPI_RX_PARTIAL_FLAG_EN
  // Per-frame sticky flag: the frame ended in the middle of a byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          partial_err <= 1'b0;
    else if (load_rise)                 partial_err <= 1'b0;
    else if (load_fall && bit_cnt != 0) partial_err <= 1'b1;
  end
`endif

  sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (push_data),
    .rd_en   (rd_ready),
    .rd_data (rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .level   (level)
  );

endmodule

// File: tb/tb_spi_rx_fifo.sv
// tb/tb_spi_rx_fifo.sv - directed self-checking bench for spi_rx_fifo
`timescale 1ns/1ps
module tb_spi_rx_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sck = 1'b0;
  logic       sdi = 1'b0;
  logic       load = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [4:0] level;
  logic       frame_done;
  logic       overflow;
`ifdef SPI_RX_PARTIAL_FLAG_EN
  logic       partial_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int fd_cnt = 0;

  always #5 clk = ~clk;

  spi_rx_fifo #(.DEPTH(16), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .sck        (sck),
    .sdi        (sdi),
    .load       (load),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .level      (level),
    .frame_done (frame_done),
    .overflow   (overflow)
`ifdef SPI_RX_PARTIAL_FLAG_EN
    ,
    .partial_err(partial_err)
`endif
  );

  always @(posedge clk) if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;

`define CHK(tag, obs, exp) \
  begin \
    n_cmp++; \
    assert ((obs) === (exp)) else begin \
      n_bad++; \
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp); \
    end \
  end

  // One SPI bit, sck period 8 clk; optionally pulse rd_ready in the cycle the
  // completed byte is pushed (push cycle precedes the rd_valid edge).
  task automatic send_bit(input logic b, input logic pop_at_push);
    sdi = b;
    repeat (4) @(negedge clk);
    sck = 1'b1;
    repeat (3) @(negedge clk);
    if (pop_at_push) rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic pop_at_push);
    for (int i = 7; i >= 0; i--) send_bit(b[i], pop_at_push && (i == 0));
  endtask

  task automatic set_load(input logic v);
    load = v;
    repeat (6) @(negedge clk);
  endtask

  task automatic pop_one();
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
  endtask

  task automatic wait_rd_valid(input string tag, input int max_cyc);
    int k;
    k = 0;
    while (rd_valid !== 1'b1 && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (rd_valid !== 1'b1) begin
      n_bad++;
      $error("FAIL %s: rd_valid not seen within %0d cycles", tag, max_cyc);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h00 || level !== 5'd0 ||
        frame_done !== 1'b0 || overflow !== 1'b0) begin
      n_bad++;
      $error("FAIL reset_state: valid=%0b data=0x%0h level=%0d fd=%0b ovf=%0b",
             rd_valid, rd_data, level, frame_done, overflow);
    end
    `CHK("reset_rd_valid", rd_valid, 1'b0)
    `CHK("reset_rd_data", rd_data, 8'h00)
    `CHK("reset_level", level, 5'd0)
    `CHK("reset_frame_done", frame_done, 1'b0)
    `CHK("reset_overflow", overflow, 1'b0)

    // sck activity with load low is ignored
    send_byte(8'hAA, 1'b0);
    repeat (4) @(negedge clk);
    `CHK("noload_level", level, 5'd0)
    `CHK("noload_rd_valid", rd_valid, 1'b0)
    `CHK("noload_frame_done_cnt", fd_cnt, 0)

    // two bytes, then single-cycle pops
    set_load(1'b1);
    send_byte(8'hA5, 1'b0);
    wait_rd_valid("lat_wait", 4);
    `CHK("lat_rd_valid", rd_valid, 1'b1)
    `CHK("lat_rd_data", rd_data, 8'hA5)
    send_byte(8'h3C, 1'b0);
    `CHK("two_level", level, 5'd2)
    `CHK("two_head", rd_data, 8'hA5)
    pop_one();
    `CHK("pop1_data", rd_data, 8'h3C)
    `CHK("pop1_level", level, 5'd1)
    pop_one();
    `CHK("pop2_level", level, 5'd0)
    `CHK("pop2_rd_valid", rd_valid, 1'b0)
    `CHK("pop2_hold_data", rd_data, 8'h3C)
    set_load(1'b0);
    `CHK("frame1_done_cnt", fd_cnt, 1)

    // 12 bits: full byte plus a discarded partial nibble
    set_load(1'b1);
    send_byte(8'hFF, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    set_load(1'b0);
    `CHK("partial_level", level, 5'd1)
    `CHK("partial_data", rd_data, 8'hFF)
    `CHK("partial_done_cnt", fd_cnt, 2)
`ifdef SPI_RX_PARTIAL_FLAG_EN
    `CHK("partial_err_set", partial_err, 1'b1)
`endif
    pop_one();

    // DEPTH+1 bytes: last one dropped
    set_load(1'b1);
`ifdef SPI_RX_PARTIAL_FLAG_EN
    `CHK("partial_err_clr", partial_err, 1'b0)
`endif
    for (int i = 0; i <= 16; i++) send_byte(8'(i), 1'b0);
    `CHK("ovf_level", level, 5'd16)
    `CHK("ovf_flag", overflow, 1'b1)
    for (int i = 0; i < 16; i++) begin
      `CHK("ovf_drain", rd_data, 8'(i))
      pop_one();
    end
    `CHK("ovf_drained_valid", rd_valid, 1'b0)
    `CHK("ovf_sticky", overflow, 1'b1)
    set_load(1'b0);
    set_load(1'b1);
    `CHK("ovf_clr_on_load", overflow, 1'b0)

    // full FIFO, push coincides with pop
    for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i), 1'b0);
    `CHK("full_level", level, 5'd16)
    send_byte(8'h77, 1'b1);
    `CHK("fullpp_level", level, 5'd16)
    `CHK("fullpp_overflow", overflow, 1'b0)
    `CHK("fullpp_head", rd_data, 8'h21)
    for (int i = 1; i < 16; i++) begin
      `CHK("fullpp_drain", rd_data, 8'h20 + 8'(i))
      pop_one();
    end
    `CHK("fullpp_last", rd_data, 8'h77)
    pop_one();
    `CHK("fullpp_empty", rd_valid, 1'b0)
    set_load(1'b0);

    // reset in the middle of a byte with load held high
    set_load(1'b1);
    send_byte(8'h5A, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0);
    `CHK("prereset_valid", rd_valid, 1'b1)
    reset = 1'b1;
    #1;
    `CHK("rst_rd_valid", rd_valid, 1'b0)
    `CHK("rst_rd_data", rd_data, 8'h00)
    `CHK("rst_level", level, 5'd0)
    `CHK("rst_overflow", overflow, 1'b0)
    `CHK("rst_frame_done", frame_done, 1'b0)
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    send_byte(8'h81, 1'b0);
    repeat (4) @(negedge clk);
    `CHK("rst_noarm_level", level, 5'd0)
    `CHK("rst_noarm_valid", rd_valid, 1'b0)
    set_load(1'b0);
    set_load(1'b1);
    send_byte(8'h81, 1'b0);
    wait_rd_valid("rst_rearm_wait", 4);
    `CHK("rst_rearm_valid", rd_valid, 1'b1)
    `CHK("rst_rearm_data", rd_data, 8'h81)
    `CHK("rst_rearm_level", level, 5'd1)
    set_load(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
